wb_arbiter: RTL and testbench

- Shares the register file's single write port (wb_e / w_baddr / wb_data) between two writeback requesters.
  - Port A: ALU pipeline, 1-cycle.
  - Port B: load/store and mul/div units, variable latency.
- Each port has a valid/ready handshake and a 1-entry holding register.
- Arbitration is fixed-priority to A, with a starvation limit for B and write-after-write ordering on the same rd.
- Drives a pending-destination mask so decode can stall on RAW hazards.

---
 rtl/wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: two valid/ready requesters share one write port.
// Fixed priority to A, with a starvation limit for B and same-rd write ordering.
module wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RSLEN      = 5,
  parameter int unsigned STARVE_LIM = 3   // legal 1..15
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [RSLEN-1:0]      a_addr,
  input  logic [XLEN-1:0]       a_data,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [RSLEN-1:0]      b_addr,
  input  logic [XLEN-1:0]       b_data,

  output logic                  wb_e,
  output logic [RSLEN-1:0]      w_baddr,
  output logic [XLEN-1:0]       wb_data,
  output logic [2**RSLEN-1:0]   pend_mask
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  // Holding registers
  logic              hold_a_valid_q, hold_a_valid_d;
  logic [RSLEN-1:0]  hold_a_addr_q,  hold_a_addr_d;
  logic [XLEN-1:0]   hold_a_data_q,  hold_a_data_d;
  logic              hold_b_valid_q, hold_b_valid_d;
  logic [RSLEN-1:0]  hold_b_addr_q,  hold_b_addr_d;
  logic [XLEN-1:0]   hold_b_data_q,  hold_b_data_d;

  // b_older_q = 1 when the held B entry was loaded no later than the held A entry
  logic              b_older_q, b_older_d;
  logic [3:0]        b_wait_q,  b_wait_d;

  // Output stage
  logic              wb_e_q,    wb_e_d;
  logic [RSLEN-1:0]  w_baddr_q, w_baddr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic same_addr;
  logic grant_a, grant_b;
  logic load_a, load_b;

  // Arbitration over held entries only
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    same_addr = hold_a_valid_q & hold_b_valid_q & (hold_a_addr_q == hold_b_addr_q);
    if (same_addr) begin
      if (b_older_q) grant_b = 1'b1;
      else           grant_a = 1'b1;
    end else if (hold_b_valid_q && (b_wait_q == StarveLim)) begin
      grant_b = 1'b1;
    end else if (hold_a_valid_q) begin
      grant_a = 1'b1;
    end else if (hold_b_valid_q) begin
      grant_b = 1'b1;
    end
  end

  assign a_ready = ~rst & (~hold_a_valid_q | grant_a);
  assign b_ready = ~rst & (~hold_b_valid_q | grant_b);

  // Writes to x0 complete the handshake but are dropped here
  assign load_a = a_valid & a_ready & (a_addr != '0);
  assign load_b = b_valid & b_ready & (b_addr != '0);

  always_comb begin
    hold_a_valid_d = hold_a_valid_q;
    hold_a_addr_d  = hold_a_addr_q;
    hold_a_data_d  = hold_a_data_q;
    if (grant_a) hold_a_valid_d = 1'b0;
    if (load_a) begin
      hold_a_valid_d = 1'b1;
      hold_a_addr_d  = a_addr;
      hold_a_data_d  = a_data;
    end
  end

  always_comb begin
    hold_b_valid_d = hold_b_valid_q;
    hold_b_addr_d  = hold_b_addr_q;
    hold_b_data_d  = hold_b_data_q;
    if (grant_b) hold_b_valid_d = 1'b0;
    if (load_b) begin
      hold_b_valid_d = 1'b1;
      hold_b_addr_d  = b_addr;
      hold_b_data_d  = b_data;
    end
  end

  // A fresh load is always younger than whatever the other slot holds; same-edge loads favour B
  always_comb begin
    b_older_d = b_older_q;
    if (load_a)      b_older_d = 1'b1;
    else if (load_b) b_older_d = 1'b0;
  end

  always_comb begin
    b_wait_d = b_wait_q;
    if (!hold_b_valid_q || grant_b) begin
      b_wait_d = '0;
    end else if (b_wait_q != StarveLim) begin
      b_wait_d = b_wait_q + 4'd1;
    end
  end

  always_comb begin
    wb_e_d    = grant_a | grant_b;
    w_baddr_d = w_baddr_q;
    wb_data_d = wb_data_q;
    if (grant_b) begin
      w_baddr_d = hold_b_addr_q;
      wb_data_d = hold_b_data_q;
    end else if (grant_a) begin
      w_baddr_d = hold_a_addr_q;
      wb_data_d = hold_a_data_q;
    end
  end

  // The output stage is not tracked: the register file forwards same-cycle writes
  always_comb begin
    pend_mask = '0;
    if (hold_a_valid_q) pend_mask[hold_a_addr_q] = 1'b1;
    if (hold_b_valid_q) pend_mask[hold_b_addr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a_valid_q <= 1'b0;
      hold_a_addr_q  <= '0;
      hold_a_data_q  <= '0;
      hold_b_valid_q <= 1'b0;
      hold_b_addr_q  <= '0;
      hold_b_data_q  <= '0;
      b_older_q      <= 1'b0;
      b_wait_q       <= '0;
      wb_e_q         <= 1'b0;
      w_baddr_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      hold_a_valid_q <= hold_a_valid_d;
      hold_a_addr_q  <= hold_a_addr_d;
      hold_a_data_q  <= hold_a_data_d;
      hold_b_valid_q <= hold_b_valid_d;
      hold_b_addr_q  <= hold_b_addr_d;
      hold_b_data_q  <= hold_b_data_d;
      b_older_q      <= b_older_d;
      b_wait_q       <= b_wait_d;
      wb_e_q         <= wb_e_d;
      w_baddr_q      <= w_baddr_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign wb_e    = wb_e_q;
  assign w_baddr = w_baddr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, x0 drop, WAW order, tie, starvation.
module tb_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RSLEN = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [RSLEN-1:0]  a_addr, b_addr;
  logic [XLEN-1:0]   a_data, b_data;
  logic              wb_e;
  logic [RSLEN-1:0]  w_baddr;
  logic [XLEN-1:0]   wb_data;
  logic [31:0]       pend_mask;

  int n_vec  = 0;
  int n_miss = 0;

  wb_arbiter #(
    .XLEN       (XLEN),
    .RSLEN      (RSLEN),
    .STARVE_LIM (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .wb_e      (wb_e),
    .w_baddr   (w_baddr),
    .wb_data   (wb_data),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_we"},   64'(wb_e),    64'd1);
    check({tag, "_addr"}, 64'(w_baddr), 64'(addr));
    check({tag, "_data"}, 64'(wb_data), 64'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // Starvation expectations, one entry per cycle after B is loaded
  logic       st_rdy  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [4:0] st_addr [9] = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

  initial begin
    int rd;
    int stalls;
    logic acc;
    logic [31:0] exp_d;

    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #1;
    check("rst_a_ready", 64'(a_ready),   64'd0);
    check("rst_b_ready", 64'(b_ready),   64'd0);
    check("rst_wb_e",    64'(wb_e),      64'd0);
    check("rst_addr",    64'(w_baddr),   64'd0);
    check("rst_data",    64'(wb_data),   64'd0);
    check("rst_pend",    64'(pend_mask), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single A write
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    check("one_a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("one_pend", 64'(pend_mask), 64'h8);
    check("one_we0",  64'(wb_e),      64'd0);
    tick();
    check_wr("one", 5'd3, 32'hDEADBEEF);
    check("one_pend_clr", 64'(pend_mask), 64'd0);
    tick();
    check("one_idle_we",   64'(wb_e),    64'd0);
    check("one_hold_addr", 64'(w_baddr), 64'd3);

    // x0 discard
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55;
    check("x0_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("x0_pend", 64'(pend_mask), 64'd0);
    check("x0_we0",  64'(wb_e),      64'd0);
    tick();
    check("x0_we1",   64'(wb_e),    64'd0);
    check("x0_data",  64'(wb_data), 64'hDEADBEEF);

    // WAW: B(r7) held behind A(r2), then younger A(r7) must wait for B
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2A;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
    tick();
    b_valid = 1'b0;
    check("waw_b_ready", 64'(b_ready), 64'd0);
    check("waw_a_ready", 64'(a_ready), 64'd1);
    a_addr = 5'd7; a_data = 32'hA;
    tick();
    a_valid = 1'b0;
    check_wr("waw1", 5'd2, 32'h2A);
    check("waw_pend", 64'(pend_mask), 64'h80);
    check("waw_a_blocked", 64'(a_ready), 64'd0);
    tick();
    check_wr("waw2", 5'd7, 32'hB);
    tick();
    check_wr("waw3", 5'd7, 32'hA);
    check("waw_pend_clr", 64'(pend_mask), 64'd0);
    tick();
    check("waw_idle", 64'(wb_e), 64'd0);

    // Same-edge tie on r4: B wins
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("tie_a_ready", 64'(a_ready),   64'd0);
    check("tie_b_ready", 64'(b_ready),   64'd1);
    check("tie_pend",    64'(pend_mask), 64'h10);
    tick();
    check_wr("tie1", 5'd4, 32'h2);
    check("tie_pend1", 64'(pend_mask), 64'h10);
    tick();
    check_wr("tie2", 5'd4, 32'h1);
    tick();
    check("tie_idle", 64'(wb_e), 64'd0);

    // Starvation: A streams r1..r8, B holds r9
    rd = 1;
    a_valid = 1'b1; a_addr = 5'(rd); a_data = 32'h100 + 32'(rd);
    b_valid = 1'b1; b_addr = 5'd9;  b_data = 32'h99;
    tick();
    b_valid = 1'b0;
    rd = 2; a_addr = 5'(rd); a_data = 32'h100 + 32'(rd);
    stalls = 0;
    for (int k = 0; k < 9; k++) begin
      check("st_ready", 64'(a_ready), 64'(st_rdy[k]));
      if (!a_ready) stalls++;
      acc = a_valid & a_ready;
      tick();
      exp_d = (st_addr[k] == 5'd9) ? 32'h99 : 32'h100 + 32'(st_addr[k]);
      check_wr("st", st_addr[k], exp_d);
      if (acc) begin
        rd++;
        if (rd > 8) begin
          a_valid = 1'b0;
        end else begin
          a_addr = 5'(rd); a_data = 32'h100 + 32'(rd);
        end
      end
    end
    check("st_stalls", 64'(stalls), 64'd1);
    tick();
    check("st_idle", 64'(wb_e), 64'd0);

    // Reset mid-operation with both slots full and a write in the output stage
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h7;
    tick();
    a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("mid_pend", 64'(pend_mask), 64'h60);
    check("mid_we",   64'(wb_e),      64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we",   64'(wb_e),      64'd0);
    check("mid_rst_pend", 64'(pend_mask), 64'd0);
    check("mid_rst_ar",   64'(a_ready),   64'd0);
    check("mid_rst_br",   64'(b_ready),   64'd0);
    check("mid_rst_addr", 64'(w_baddr),   64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_we",   64'(wb_e),      64'd0);
      check("post_rst_pend", 64'(pend_mask), 64'd0);
    end
    check("post_rst_addr", 64'(w_baddr), 64'd0);
    check("post_rst_data", 64'(wb_data), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
